// File: rtl/perf_pkg.sv
// Shared types and default sizes for the perf event reader.
package perf_pkg;

    localparam int PERF_EVENT_NUM = 16;
    localparam int PERF_CNT_WIDTH = 32;

    typedef logic [PERF_CNT_WIDTH-1:0] perf_cnt_t;

    typedef enum logic [0:0] {
        IDLE,
        STREAM
    } perf_dump_state_t;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with increment and clear.
// Clear takes priority over increment.
// Optional build macro PERF_SATURATE_EN: when defined the counter sticks at all-ones
// instead of wrapping to zero.
module perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    // Count one per strobe; clear wins over a same-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
`ifdef PERF_SATURATE_EN
            if (count != {W{1'b1}}) begin
                count <= count + W'(1);
            end
`else
            count <= count + W'(1);
`endif
        end
    end

endmodule

// File: rtl/perf_event_reader.sv
// Perf event reader: one counter per event strobe, a registered random-access
// read port, and a snapshot dump stream with a valid/ready handshake.
// Optional build macro PERF_SATURATE_EN (applied inside perf_counter) makes
// counters saturate instead of wrap.
//
// Handshake: a dump beat transfers on a cycle where dump_valid and dump_ready
// are both high; while dump_ready is low the beat (idx, value, valid) holds.
module perf_event_reader
    import perf_pkg::*;
#(
    parameter int   EVENT_NUM = PERF_EVENT_NUM,
    parameter int   CNT_WIDTH = PERF_CNT_WIDTH,
    localparam int  IDX_WIDTH = $clog2(EVENT_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EVENT_NUM-1:0] events,
    input  logic                 clear,
    input  logic                 rd_en,
    input  logic [IDX_WIDTH-1:0] rd_idx,
    output logic [CNT_WIDTH-1:0] rd_data,
    input  logic                 dump_req,
    output logic                 dump_busy,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [IDX_WIDTH-1:0] dump_idx,
    output logic [CNT_WIDTH-1:0] dump_value,
    output logic                 dump_last
);

    logic [CNT_WIDTH-1:0] cnt  [EVENT_NUM];
    logic [CNT_WIDTH-1:0] snap [EVENT_NUM];

    perf_dump_state_t     state;
    perf_dump_state_t     state_nxt;
    logic [IDX_WIDTH-1:0] idx_nxt;
    logic                 snap_load;
    logic                 beat_adv;
    logic [CNT_WIDTH-1:0] rd_mux;
    logic [CNT_WIDTH-1:0] snap_mux;

    genvar g;
    generate
        for (g = 0; g < EVENT_NUM; g++) begin : g_cnt
            perf_counter #(.W(CNT_WIDTH)) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (events[g]),
                .clear (clear),
                .count (cnt[g])
            );
        end
    endgenerate

    // Read mux over live counters; an index with no counter reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < EVENT_NUM; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    // Registered read result; holds when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_mux;
        end
    end

    // Snapshot value for the beat that follows the current one.
    always_comb begin
        snap_mux = '0;
        for (int i = 0; i < EVENT_NUM; i++) begin
            if (idx_nxt == IDX_WIDTH'(i)) begin
                snap_mux = snap[i];
            end
        end
    end

    // Dump FSM next state: accept a request only in IDLE, step on each handshake.
    always_comb begin
        state_nxt = state;
        idx_nxt   = dump_idx;
        snap_load = 1'b0;
        beat_adv  = 1'b0;
        case (state)
            IDLE: begin
                if (dump_req) begin
                    state_nxt = STREAM;
                    idx_nxt   = '0;
                    snap_load = 1'b1;
                end
            end
            STREAM: begin
                if (dump_ready) begin
                    if (dump_last) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt  = dump_idx + IDX_WIDTH'(1);
                        beat_adv = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Dump FSM state, beat index and beat value registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            dump_idx   <= '0;
            dump_value <= '0;
        end else begin
            state    <= state_nxt;
            dump_idx <= idx_nxt;
            if (snap_load) begin
                // Snapshot is being written this edge, so beat 0 comes straight
                // from the live counter it is copied from.
                dump_value <= cnt[0];
            end else if (beat_adv) begin
                dump_value <= snap_mux;
            end
        end
    end

    // Snapshot array: captured once per accepted dump request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EVENT_NUM; i++) begin
                snap[i] <= '0;
            end
        end else if (snap_load) begin
            for (int i = 0; i < EVENT_NUM; i++) begin
                snap[i] <= cnt[i];
            end
        end
    end

    assign dump_busy  = (state == STREAM);
    assign dump_valid = (state == STREAM);
    assign dump_last  = (state == STREAM) && (dump_idx == IDX_WIDTH'(EVENT_NUM - 1));

endmodule
